// File: rtl/prog_counter_mod.sv
// Programmable up/down counter driven by a slow asynchronous count strobe.
// Every pin input passes through a SYNC_STAGES-deep synchroniser. Rising
// edges of the synchronised strobe and load inputs then drive counting and
// loading. The terminal value, step and wrap/saturate mode are programmable.
module prog_counter_mod #(
  parameter int WIDTH       = 8,
  parameter int STEP_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clk_in,
  input  logic              load,
  input  logic              up_down,
  input  logic              saturate,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              at_zero,
  output logic              at_limit
);

  // All pins share one synchroniser chain. Each bit is still an independent
  // flop chain; the buses must be held quasi-static by the source.
  localparam int BUS_W = 5 + STEP_W + 2 * WIDTH;

  logic [BUS_W-1:0]                  pin_bus;
  logic [BUS_W-1:0]                  s_bus;
  logic [SYNC_STAGES-1:0][BUS_W-1:0] sync_q, sync_d;

  logic              s_enable, s_clk, s_load, s_up_down, s_saturate;
  logic [STEP_W-1:0] s_step;
  logic [WIDTH-1:0]  s_load_val, s_limit;

  logic              d_clk_q, d_clk_d;
  logic              d_load_q, d_load_d;
  logic              rise_clk, rise_load;

  logic [WIDTH-1:0]  count_q, count_d;
  logic              tc_q, tc_d;

  // Arithmetic is done one bit wider so that an up-count overflow past
  // the limit is visible even when limit is all-ones.
  logic [WIDTH:0]    step_ext;
  logic [WIDTH:0]    raw_up;

  assign pin_bus = {enable, clk_in, load, up_down, saturate, step, load_val, limit};
  assign s_bus   = sync_q[SYNC_STAGES-1];
  assign {s_enable, s_clk, s_load, s_up_down, s_saturate, s_step, s_load_val, s_limit} = s_bus;

  assign rise_clk  = s_clk & ~d_clk_q;
  assign rise_load = s_load & ~d_load_q;

  assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, s_step};
  assign raw_up   = {1'b0, count_q} + step_ext;

  // Synchroniser shift: stage 0 samples the pins, the last stage feeds the logic.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = pin_bus;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Next count / terminal-count pulse. A load beats a simultaneous count
  // event. While disabled, edges are still consumed by the history flops.
  always_comb begin
    count_d  = count_q;
    tc_d     = 1'b0;
    d_clk_d  = s_clk;
    d_load_d = s_load;
    if (s_enable) begin
      if (rise_load) begin
        count_d = s_load_val;
      end else if (rise_clk && (s_step != '0)) begin
        if (s_up_down) begin
          if (raw_up > {1'b0, s_limit}) begin
            tc_d    = 1'b1;
            count_d = s_saturate ? s_limit : '0;
          end else begin
            count_d = raw_up[WIDTH-1:0];
          end
        end else begin
          if ({1'b0, count_q} < step_ext) begin
            tc_d    = 1'b1;
            count_d = s_saturate ? '0 : s_limit;
          end else begin
            count_d = count_q - step_ext[WIDTH-1:0];
          end
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      d_clk_q  <= 1'b0;
      d_load_q <= 1'b0;
      count_q  <= '0;
      tc_q     <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      d_clk_q  <= d_clk_d;
      d_load_q <= d_load_d;
      count_q  <= count_d;
      tc_q     <= tc_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign at_zero  = (count_q == '0);
  assign at_limit = (count_q == s_limit);

endmodule

// File: tb/tb_prog_counter_mod.sv
// Self-checking bench for prog_counter_mod: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_prog_counter_mod;
  localparam int W  = 8;
  localparam int SW = 4;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0, clk_in = 1'b0, load = 1'b0;
  logic          up_down = 1'b1, saturate = 1'b0;
  logic [SW-1:0] step = '0;
  logic [W-1:0]  load_val = '0, limit = '0;
  logic [W-1:0]  count;
  logic          tc, at_zero, at_limit;

  int checks = 0;
  int errors = 0;

  prog_counter_mod #(.WIDTH(W), .STEP_W(SW), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clk_in(clk_in), .load(load),
    .up_down(up_down), .saturate(saturate), .step(step), .load_val(load_val),
    .limit(limit), .count(count), .tc(tc), .at_zero(at_zero), .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  // Reference model: pins seen at an edge reach the logic S edges later.
  typedef struct packed {
    logic          en, ck, ld, ud, sat;
    logic [SW-1:0] stp;
    logic [W-1:0]  lv, lim;
  } pins_t;

  pins_t hist [S];
  int    m_count = 0;
  bit    m_tc = 0;
  bit    m_prev_ck = 0, m_prev_ld = 0;
  int    m_lim_s = 0;

  always @(posedge clk) begin
    pins_t s;
    if (rst) begin
      for (int i = 0; i < S; i++) hist[i] = '0;
      m_prev_ck = 0;
      m_prev_ld = 0;
      m_count   = 0;
      m_tc      = 0;
    end else begin
      s    = hist[S-1];
      m_tc = 0;
      if (s.en) begin
        if (s.ld && !m_prev_ld) begin
          m_count = int'(s.lv);
        end else if (s.ck && !m_prev_ck && s.stp != 0) begin
          if (s.ud) begin
            if (m_count + int'(s.stp) > int'(s.lim)) begin
              m_tc = 1;
              m_count = s.sat ? int'(s.lim) : 0;
            end else begin
              m_count = m_count + int'(s.stp);
            end
          end else begin
            if (m_count < int'(s.stp)) begin
              m_tc = 1;
              m_count = s.sat ? 0 : int'(s.lim);
            end else begin
              m_count = m_count - int'(s.stp);
            end
          end
        end
      end
      m_prev_ck = s.ck;
      m_prev_ld = s.ld;
      for (int i = S - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = '{enable, clk_in, load, up_down, saturate, step, load_val, limit};
    end
    m_lim_s = int'(hist[S-1].lim);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a 4-high/4-low pulse on load or clk_in and counts tc cycles seen.
  task automatic pulse(input bit is_load, output int tcs);
    tcs = 0;
    if (is_load) load = 1'b1; else clk_in = 1'b1;
    repeat (4) begin @(negedge clk); if (tc) tcs++; end
    if (is_load) load = 1'b0; else clk_in = 1'b0;
    repeat (4) begin @(negedge clk); if (tc) tcs++; end
  endtask

  task automatic test_reset();
    int tcs = 0;
    rst = 1'b1;
    repeat (4) begin clk_in = ~clk_in; @(negedge clk); if (tc) tcs++; end
    checks++;
    if (count !== 8'h00 || tcs != 0 || at_zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: count=%h tc_cycles=%0d at_zero=%b, required 00/0/1", count, tcs, at_zero);
    end
    rst = 1'b0;
    clk_in = 1'b0;
    wait_cyc(2);
    checks++;
    if (count !== 8'h00) begin
      errors++;
      $display("FAIL reset_release: count=%h required 00", count);
    end
  endtask

  task automatic test_count_up();
    int tcs;
    enable = 1'b1; up_down = 1'b1; step = 4'd1; limit = 8'hFF; saturate = 1'b0;
    wait_cyc(4);
    // Stage-1 capture at the next edge; count must move exactly 2 edges later.
    clk_in = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(negedge clk);
      checks++;
      if (count !== ((e == 2) ? 8'h01 : 8'h00)) begin
        errors++;
        $display("FAIL latency_edge%0d: count=%h required %h", e, count, (e == 2) ? 8'h01 : 8'h00);
      end
    end
    wait_cyc(1);
    clk_in = 1'b0;
    wait_cyc(4);
    for (int p = 2; p <= 3; p++) begin
      pulse(1'b0, tcs);
      checks++;
      if (count !== W'(p) || tcs != 0) begin
        errors++;
        $display("FAIL count_up_%0d: count=%h tc_cycles=%0d, required %h/0", p, count, tcs, W'(p));
      end
    end
  endtask

  task automatic test_wrap();
    int tcs;
    load_val = 8'hFE;
    wait_cyc(4);
    pulse(1'b1, tcs);
    checks++;
    if (count !== 8'hFE || tcs != 0) begin
      errors++;
      $display("FAIL wrap_load: count=%h tc_cycles=%0d, required FE/0", count, tcs);
    end
    step = 4'd3;
    wait_cyc(4);
    pulse(1'b0, tcs);
    checks++;
    if (count !== 8'h00 || tcs != 1) begin
      errors++;
      $display("FAIL wrap_up: count=%h tc_cycles=%0d, required 00/1", count, tcs);
    end
    load_val = 8'h01;
    wait_cyc(4);
    pulse(1'b1, tcs);
    up_down = 1'b0;
    wait_cyc(4);
    pulse(1'b0, tcs);
    checks++;
    if (count !== 8'hFF || tcs != 1) begin
      errors++;
      $display("FAIL wrap_down: count=%h tc_cycles=%0d, required FF/1", count, tcs);
    end
  endtask

  task automatic test_saturate();
    int tcs;
    saturate = 1'b1; limit = 8'h64; load_val = 8'h62; up_down = 1'b1; step = 4'd5;
    wait_cyc(4);
    pulse(1'b1, tcs);
    pulse(1'b0, tcs);
    checks++;
    if (count !== 8'h64 || tcs != 1 || at_limit !== 1'b1) begin
      errors++;
      $display("FAIL sat_up: count=%h tc_cycles=%0d at_limit=%b, required 64/1/1", count, tcs, at_limit);
    end
    pulse(1'b0, tcs);
    checks++;
    if (count !== 8'h64 || tcs != 1) begin
      errors++;
      $display("FAIL sat_up_again: count=%h tc_cycles=%0d, required 64/1", count, tcs);
    end
    load_val = 8'h03; up_down = 1'b0;
    wait_cyc(4);
    pulse(1'b1, tcs);
    pulse(1'b0, tcs);
    checks++;
    if (count !== 8'h00 || tcs != 1 || at_zero !== 1'b1) begin
      errors++;
      $display("FAIL sat_down: count=%h tc_cycles=%0d at_zero=%b, required 00/1/1", count, tcs, at_zero);
    end
  endtask

  task automatic test_priority();
    int tcs = 0;
    saturate = 1'b0; limit = 8'hFF; load_val = 8'h40; up_down = 1'b1; step = 4'd1;
    wait_cyc(4);
    load = 1'b1; clk_in = 1'b1;
    repeat (4) begin @(negedge clk); if (tc) tcs++; end
    load = 1'b0; clk_in = 1'b0;
    repeat (4) begin @(negedge clk); if (tc) tcs++; end
    checks++;
    if (count !== 8'h40 || tcs != 0) begin
      errors++;
      $display("FAIL load_beats_count: count=%h tc_cycles=%0d, required 40/0", count, tcs);
    end
    enable = 1'b0;
    wait_cyc(4);
    pulse(1'b0, tcs);
    pulse(1'b0, tcs);
    checks++;
    if (count !== 8'h40) begin
      errors++;
      $display("FAIL disabled_hold: count=%h required 40", count);
    end
    clk_in = 1'b1;
    wait_cyc(4);
    enable = 1'b1;
    wait_cyc(5);
    checks++;
    if (count !== 8'h40) begin
      errors++;
      $display("FAIL enable_under_high_clk: count=%h required 40", count);
    end
    clk_in = 1'b0;
    wait_cyc(4);
  endtask

  task automatic test_reset_mid();
    int tcs = 0;
    clk_in = 1'b1;
    @(negedge clk);
    rst = 1'b1; clk_in = 1'b0;
    repeat (2) begin @(negedge clk); if (tc) tcs++; end
    rst = 1'b0;
    repeat (5) begin @(negedge clk); if (tc) tcs++; end
    checks++;
    if (count !== 8'h00 || tcs != 0) begin
      errors++;
      $display("FAIL reset_mid: count=%h tc_cycles=%0d, required 00/0", count, tcs);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 79) == 0);
      enable   = ($urandom_range(0, 7) != 0);
      clk_in   = ($urandom_range(0, 2) == 0) ? ~clk_in : clk_in;
      load     = ($urandom_range(0, 11) == 0);
      up_down  = ($urandom_range(0, 15) == 0) ? ~up_down : up_down;
      saturate = ($urandom_range(0, 15) == 0) ? ~saturate : saturate;
      if ($urandom_range(0, 7) == 0) step = SW'($urandom);
      if ($urandom_range(0, 7) == 0) load_val = W'($urandom);
      if ($urandom_range(0, 9) == 0) limit = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
      @(negedge clk);
      checks++;
      if (count !== W'(m_count) || tc !== m_tc ||
          at_zero !== (m_count == 0) || at_limit !== (m_count == m_lim_s)) begin
        errors++;
        $display("FAIL random_cyc%0d: count=%h tc=%b z=%b l=%b, required %h/%b/%b/%b",
                 c, count, tc, at_zero, at_limit, W'(m_count), m_tc, m_count == 0, m_count == m_lim_s);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count_up();
    test_wrap();
    test_saturate();
    test_priority();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
